uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  Serial UART receiver (8N1, LSB first, 16x oversampling) feeding the RX FIFO write port.
//  Sits between the rx pad (or the tx loopback) and the RX FIFO inside the UART top level.
//  Synchronises rx, rejects start glitches and samples each bit at mid-bit.
//  Emits one write strobe per good byte; flags framing and overrun errors.
// PARAMETERS
//  CLK_FREQ_HZ  7372800  frequency of clk in Hz
//  BAUD         115200   line rate in bit/s
//  OVERSAMPLE   16       sample ticks per bit; power of 2, >= 8
//  DATA_BITS    8        data bits per frame, 5..8
// PORTS
//  clk          in   1          system clock (clock-wizard output)
//  rst          in   1          asynchronous reset, active-high
//  rx           in   1          serial input, idle high, asynchronous to clk
//  rx_fifo_full in   1          RX FIFO full flag
//  rx_data      out  DATA_BITS  received byte, valid while rx_valid=1, held until next byte
//  rx_valid     out  1          1-cycle write strobe to the RX FIFO
//  framing_err  out  1          1-cycle pulse: stop bit sampled low
//  overrun_err  out  1          1-cycle pulse: byte dropped because rx_fifo_full=1
//  busy         out  1          high from start-edge detect until return to IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE; counters=0; sync flops=1; rx_data=0.
//    rx_valid, framing_err, overrun_err and busy are all 0.
//  - rx passes through a 2-FF synchroniser; all decisions use the 2nd stage (rx_s).
//  - Tick: divisor DIV=CLK_FREQ_HZ/(BAUD*OVERSAMPLE), truncated, minimum 1.
//    Default DIV=4. tick is a 1-clk pulse every DIV clocks. The divider is free-running
//    except that it reloads to 0 on start-edge detect, so ticks are phase-aligned to the edge.
//  - sample_cnt is log2(OVERSAMPLE) bits, counts ticks and wraps naturally.
//    bit_cnt counts 0..DATA_BITS-1.
//  - FSM IDLE -> START -> DATA -> STOP -> IDLE:
//    IDLE : rx_s falling edge (previous 1, now 0) -> START, sample_cnt=0, busy=1.
//    START: tick with sample_cnt==OVERSAMPLE/2-1 (mid start bit):
//           rx_s==0 -> DATA with sample_cnt=0, bit_cnt=0;
//           rx_s==1 -> IDLE (glitch rejected, no outputs pulse).
//    DATA : tick with sample_cnt==OVERSAMPLE-1 -> shift rx_s in at the MSB of shreg
//           (LSB-first line order). At bit_cnt==DATA_BITS-1 -> STOP, else bit_cnt++.
//    STOP : tick with sample_cnt==OVERSAMPLE-1 (mid stop bit) -> IDLE, and:
//           rx_s==0                  -> framing_err=1 for 1 clk; rx_data unchanged.
//           rx_s==1, rx_fifo_full==1 -> overrun_err=1 for 1 clk; rx_data unchanged.
//           rx_s==1, rx_fifo_full==0 -> rx_data<=shreg, rx_valid=1 for 1 clk.
//  - Error pulses and rx_valid are registered and mutually exclusive.
//  - Latency: the strobe rises on the clk after the mid-stop tick. That is ~9.5 bit
//    times after the start edge, plus 2-3 clk of synchroniser delay.
//  - Returning to IDLE at mid-stop lets a back-to-back start edge with zero idle be caught.
//  - After a framing error the edge detector requires rx_s to go high first,
//    so a held-low (break) line produces exactly one framing_err.
//  - rx_fifo_full is sampled only in the mid-stop cycle.
//  - rst asserted mid-frame: immediate abort to the reset state; the partial byte is lost.
// STRUCTURE
//  - Shared package uart_pkg holds:
//    state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
//    the DIV computation function; the default CLK_FREQ_HZ/BAUD constants, also used by the TX side.
//  - One sub-module uart_baud_tick (divider with sync reload, tick output), shared with the TX side.
//  - The synchroniser, FSM and shift register are inline.
// TESTING (clk 7.3728 MHz, 115200 baud, bit = 64 clk)
//  1. Drive 0xA5 as 8N1 -> exactly one rx_valid, rx_data=8'hA5,
//     strobe 608+/-4 clk after the start edge; no error pulses.
//  2. 20-clk low glitch on idle rx -> FSM returns to IDLE; busy falls;
//     no rx_valid or error pulse.
//  3. 0x3C with stop bit forced 0 -> one framing_err, no rx_valid, rx_data holds its old value.
//     rx held low 2000 clk afterwards -> no further pulses.
//  4. rx_fifo_full=1 during frame 0x5A -> one overrun_err, no rx_valid.
//     Next frame 0x11 with full=0 -> rx_data=8'h11.
//  5. Back-to-back 0x00 then 0xFF with zero idle between frames -> two rx_valid strobes
//     with data 0x00 and 0xFF.
//  6. rst pulsed at mid data bit 4 -> all outputs 0 within the same clk.
//     Next frame 0x81 -> rx_data=8'h81.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the receive and transmit sides:
//   - receiver state encoding
//   - default clock / line-rate constants
//   - baud divisor computation
// -----------------------------------------------------------------------------
package uart_pkg;

    // Receiver FSM encoding; values are fixed so they read the same in waves
    // on both sides of the UART.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned DEFAULT_CLK_FREQ_HZ = 32'd7372800;
    localparam int unsigned DEFAULT_BAUD        = 32'd115200;
    localparam int unsigned DEFAULT_OVERSAMPLE  = 32'd16;
    localparam int unsigned DEFAULT_DATA_BITS   = 32'd8;

    // Clocks per oversample tick, truncated, never below one.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned d;
        d = clk_hz / (baud * os);
        if (d == 32'd0) begin
            d = 32'd1;
        end else begin
            d = d;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled_if
// Receiver-to-RX-FIFO write side bundle.
//   rx_fifo_full : FIFO full flag (FIFO -> receiver)
//   rx_data      : received byte, held until the next good byte
//   rx_valid     : one-cycle write strobe
//   framing_err  : one-cycle pulse, stop bit sampled low
//   overrun_err  : one-cycle pulse, byte dropped because the FIFO was full
//   busy         : receiver is inside a frame
// master = receiver, slave = FIFO / status consumer.
// -----------------------------------------------------------------------------
interface uart_rx_oversampled_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx_fifo_full;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 framing_err;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        input  rx_fifo_full,
        output rx_data,
        output rx_valid,
        output framing_err,
        output overrun_err,
        output busy
    );

    modport slave (
        output rx_fifo_full,
        input  rx_data,
        input  rx_valid,
        input  framing_err,
        input  overrun_err,
        input  busy
    );
endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divide-by-DIV counter producing a one-clock tick.
// Ports:
//   clk      : system clock
//   rst      : asynchronous reset, active-high
//   reload_i : synchronous reload of the counter to 0 (phase-aligns ticks)
//   tick_o   : high for one clock every DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic reload_i,
    output logic tick_o
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload wins, otherwise wrap at DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The tick is decoded from the counter so the first tick after a reload
    // lands exactly DIV clocks after the reload.
    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
// 8N1-style UART receiver, LSB first, OVERSAMPLE ticks per bit, writing good
// bytes into the RX FIFO and flagging framing / overrun errors.
// Ports:
//   clk     : system clock
//   rst     : asynchronous reset, active-high
//   rx      : serial line, idle high, asynchronous to clk
//   fifo_if : RX FIFO write side (see uart_rx_oversampled_if)
// -----------------------------------------------------------------------------
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int unsigned BAUD        = DEFAULT_BAUD,
    parameter int unsigned OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    uart_rx_oversampled_if.master fifo_if
);
    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] MID_START   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

    // Synchroniser and edge history
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;

    // FSM and datapath
    rx_state_e            state_q,       state_d;
    logic [SW-1:0]        sample_cnt_q,  sample_cnt_d;
    logic [BW-1:0]        bit_cnt_q,     bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,       shreg_d;
    logic [DATA_BITS-1:0] rx_data_q,     rx_data_d;
    logic                 rx_valid_q,    rx_valid_d;
    logic                 framing_err_q, framing_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 busy_q,        busy_d;

    logic tick_s;
    logic reload_s;
    logic start_edge_s;

    // Two-stage synchroniser plus one history flop; all reset to the idle level
    // so leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // A held-low line after a framing error never re-triggers: the edge needs
    // rx_s to have been high on the previous clock.
    assign start_edge_s = rx_prev_q & ~rx_s_q;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .reload_i (reload_s),
        .tick_o   (tick_s)
    );

    // Next-state, datapath and output-pulse decode.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        framing_err_d = 1'b0;
        overrun_err_d = 1'b0;
        reload_s      = 1'b0;
        if (tick_s) begin
            sample_cnt_d = sample_cnt_q + SW'(1);
        end else begin
            sample_cnt_d = sample_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_d      = ST_START;
                    sample_cnt_d = '0;
                    reload_s     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (sample_cnt_q == MID_START)) begin
                    if (!rx_s_q) begin
                        state_d      = ST_DATA;
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                // sample_cnt wraps to 0 on its own here, keeping mid-bit phase.
                if (tick_s && (sample_cnt_q == LAST_SAMPLE)) begin
                    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a
                // back-to-back start edge.
                if (tick_s && (sample_cnt_q == LAST_SAMPLE)) begin
                    state_d = ST_IDLE;
                    if (!rx_s_q) begin
                        framing_err_d = 1'b1;
                    end else if (fifo_if.rx_fifo_full) begin
                        overrun_err_d = 1'b1;
                    end else begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sample_cnt_q  <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_cnt_q  <= sample_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            overrun_err_q <= overrun_err_d;
            busy_q        <= busy_d;
        end
    end

    assign fifo_if.rx_data     = rx_data_q;
    assign fifo_if.rx_valid    = rx_valid_q;
    assign fifo_if.framing_err = framing_err_q;
    assign fifo_if.overrun_err = overrun_err_q;
    assign fifo_if.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampled
// Drives whole UART frames (64 clk per bit) and compares every rx_valid /
// framing_err / overrun_err pulse against an expected-event queue built from
// the frame contents alone (stop-bit level, FIFO-full flag, data byte).
// -----------------------------------------------------------------------------
module tb_uart_rx_oversampled;
    localparam int BIT_CLK   = 64;
    localparam int FRAME_CLK = 10 * BIT_CLK;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_OERR  = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_rx_oversampled_if #(.DATA_BITS(8)) fifo_if ();

    uart_rx_oversampled #(
        .CLK_FREQ_HZ (7372800),
        .BAUD        (115200),
        .OVERSAMPLE  (16),
        .DATA_BITS   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .fifo_if (fifo_if.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int obs_ev[$];
    int obs_cyc[$];
    int exp_ev[$];
    logic [7:0] model_data = 8'h00;

    function automatic int make_ev(input logic [2:0] k, input logic [7:0] d);
        return int'({21'd0, k, d});
    endfunction

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse (any combination, so overlaps show up too).
    always @(negedge clk) begin
        if (fifo_if.rx_valid || fifo_if.framing_err || fifo_if.overrun_err) begin
            obs_ev.push_back(make_ev({fifo_if.rx_valid, fifo_if.framing_err,
                                      fifo_if.overrun_err}, fifo_if.rx_data));
            obs_cyc.push_back(cyc);
        end
    end

    // Drive the first nclk clocks of a 10-bit frame (bit 0 = start bit).
    task automatic drive_line(input logic [9:0] frame, input int nclk);
        for (int i = 0; i < nclk; i++) begin
            rx = frame[i / BIT_CLK];
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: outcome depends only on stop level, full flag, data.
    task automatic send(input logic [7:0] d, input logic stop_bit,
                        input logic full, input int gap);
        if (!stop_bit) begin
            exp_ev.push_back(make_ev(K_FERR, model_data));
        end else if (full) begin
            exp_ev.push_back(make_ev(K_OERR, model_data));
        end else begin
            model_data = d;
            exp_ev.push_back(make_ev(K_VALID, d));
        end
        fifo_if.rx_fifo_full = full;
        drive_line({stop_bit, d, 1'b0}, FRAME_CLK);
        fifo_if.rx_fifo_full = 1'b0;
        if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic settle_and_check(input string tag);
        rx = 1'b1;
        repeat (FRAME_CLK + 60) @(posedge clk);
        #1;
        check({tag, "_nev"}, obs_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
            check($sformatf("%s_ev%0d", tag, i), obs_ev[i], exp_ev[i]);
        end
        check({tag, "_busy"}, int'(fifo_if.busy), 0);
        check({tag, "_data"}, int'(fifo_if.rx_data), int'(model_data));
        obs_ev.delete();
        obs_cyc.delete();
        exp_ev.delete();
    endtask

    initial begin
        int c0;
        fifo_if.rx_fifo_full = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", int'(fifo_if.rx_valid), 0);
        check("rst_ferr",  int'(fifo_if.framing_err), 0);
        check("rst_oerr",  int'(fifo_if.overrun_err), 0);
        check("rst_busy",  int'(fifo_if.busy), 0);
        check("rst_data",  int'(fifo_if.rx_data), 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // 1: single good frame, latency 608 clk plus synchroniser delay
        c0 = cyc;
        send(8'hA5, 1'b1, 1'b0, 0);
        rx = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        if (obs_cyc.size() > 0) begin
            check("t1_lat_ok", int'((obs_cyc[0] - c0 >= 604) && (obs_cyc[0] - c0 <= 615)), 1);
        end else begin
            check("t1_lat_seen", 0, 1);
        end
        settle_and_check("t1");

        // 2: 20-clk glitch is rejected
        rx = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("t2_busy_hi", int'(fifo_if.busy), 1);
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("t2_busy_lo", int'(fifo_if.busy), 0);
        settle_and_check("t2");

        // 3: framing error, then break held low yields no more pulses
        send(8'h3C, 1'b0, 1'b0, 0);
        repeat (2000) @(posedge clk);
        #1;
        settle_and_check("t3");

        // 4: overrun, then a good frame
        send(8'h5A, 1'b1, 1'b1, 50);
        send(8'h11, 1'b1, 1'b0, 0);
        settle_and_check("t4");

        // 5: back-to-back frames with zero idle
        send(8'h00, 1'b1, 1'b0, 0);
        send(8'hFF, 1'b1, 1'b0, 0);
        settle_and_check("t5");

        // 6: reset at mid data bit 4 aborts the frame immediately
        drive_line({1'b1, 8'hC3, 1'b0}, 5 * BIT_CLK + BIT_CLK / 2);
        check("t6_busy_pre", int'(fifo_if.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", int'(fifo_if.busy), 0);
        check("t6_rst_data", int'(fifo_if.rx_data), 0);
        check("t6_rst_valid", int'(fifo_if.rx_valid), 0);
        rx = 1'b1;
        model_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        obs_ev.delete();
        obs_cyc.delete();
        send(8'h81, 1'b1, 1'b0, 0);
        settle_and_check("t6");

        // Random frames: data, stop level, full flag and idle gap all random.
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            logic       sb;
            logic       fl;
            int         gap;
            d   = 8'($urandom_range(0, 255));
            sb  = ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 4) == 0);
            gap = sb ? int'($urandom_range(0, 80)) : int'($urandom_range(8, 80));
            send(d, sb, fl, gap);
        end
        settle_and_check("rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
